ctrl_sequencer: RTL and testbench
=================================

// Module: ctrl_sequencer
// PURPOSE
//  Consumes the 15-bit control bundle from the opcode decoder and sequences one instruction over several cycles.
//  Drives ALU, memory and register-file enables at the correct step, waits on memory, and signals retirement.
//  Sits between the decoder and the datapath.
//  Accepts a new bundle only when idle, through a valid/ready handshake.
// PARAMETERS
//  MEM_TIMEOUT  16  max cycles to wait for mem_ready in MEM before flagging error (>=1)
//  CNT_W        16  width of retired-instruction counter
// PORTS
//  clk          in   1      single clock, all logic on rising edge
//  rst_n        in   1      synchronous, active-low reset
//  ctrl_valid   in   1      ctrl_word valid
//  ctrl_ready   out  1      sequencer can accept a bundle (IDLE only)
//  ctrl_word    in   15     {regDst[14],branch[13],memRead[12],memToReg[11],aluOp[10:3],memWrite[2],aluSrc[1],regWrite[0]}
//  mem_ready    in   1      memory completed current access
//  alu_en       out  1      ALU evaluate strobe (EXEC)
//  alu_op       out  8      latched aluOp, held from accept until return to IDLE
//  alu_src      out  1      latched aluSrc
//  reg_dst      out  1      latched regDst
//  br_eval      out  1      branch compare strobe (EXEC, only when branch=1)
//  mem_rd_en    out  1      held high throughout MEM for reads
//  mem_wr_en    out  1      held high throughout MEM for writes
//  mem_to_reg   out  1      writeback mux select, valid during WB
//  reg_wr_en    out  1      one-cycle register-file write strobe (WB)
//  done         out  1      one-cycle retire pulse
//  err          out  1      one-cycle error pulse (illegal bundle or memory timeout)
//  retired      out  CNT_W  count of done pulses, wraps at 2^CNT_W
// BEHAVIOUR
//  Reset: state=IDLE; all outputs and the latched word are 0; ctrl_ready=1 from the first cycle after reset.
//  States: IDLE, EXEC, MEM, WB.
//   IDLE: ctrl_ready=1. On ctrl_valid&ctrl_ready, latch the word.
//    Word==0 (NOP): done=1 next cycle, stay in IDLE.
//    memRead&memWrite (illegal): err=1 next cycle, no enables, stay in IDLE.
//    Otherwise -> EXEC.
//   EXEC (exactly 1 cycle): alu_en=1; br_eval=branch.
//    -> MEM if memRead|memWrite; else -> WB if regWrite; else done=1 -> IDLE.
//   MEM: mem_rd_en=memRead, mem_wr_en=memWrite; timeout counter increments each cycle.
//    mem_ready=1 -> WB if regWrite, else done=1 -> IDLE.
//    Counter reaching MEM_TIMEOUT without mem_ready -> err=1, no done, drop enables -> IDLE.
//    mem_ready sampled in the same cycle the counter expires counts as success.
//   WB (exactly 1 cycle): reg_wr_en=1, mem_to_reg=latched memToReg; done=1 -> IDLE.
//  done/err: registered and coincident with the last active state cycle (NOP/illegal: the cycle after accept).
//   Never asserted together.
//  Latency accept->done:
//   ALU-only with regWrite: 2 cycles (EXEC, WB).
//   Load: 2 + mem wait cycles (1 minimum).
//   Store: 1 + mem wait cycles.
//  ctrl_ready=0 outside IDLE; ctrl_valid is ignored there and the word must be held by the sender.
//  retired increments on each done, wraps to 0, never increments on err.
//  Reset asserted mid-instruction: abandons it at the next edge.
//   No done/err; all enables 0; retired cleared.
//  mem_ready outside MEM is ignored.
// STRUCTURE
//  Shared package ctrl_pkg:
//   bit-position localparams for the 15-bit bundle (CW_REGDST=14 ... CW_REGWRITE=0);
//   state encoding localparams (IDLE=2'd0, EXEC=2'd1, MEM=2'd2, WB=2'd3).
//  The decoder must use the same package.
//  One sub-module: ctrl_mem_timer (load/clear, count-enable, expired flag, width $clog2(MEM_TIMEOUT+1)).
//  Everything else stays flat.
// TESTING
//  ALU op: word with regDst=1, aluOp=8'h01, regWrite=1 (15'h4009) accepted at cycle 0
//   -> alu_en@1, reg_wr_en+done@2, retired=1.
//  Load: memRead=1, memToReg=1, regWrite=1; mem_ready high after 3 MEM cycles
//   -> mem_rd_en high 3 cycles, reg_wr_en+mem_to_reg=1 next cycle, done.
//  Store timeout: memWrite=1, mem_ready held 0, MEM_TIMEOUT=4
//   -> mem_wr_en high 4 cycles, err pulse, no done, retired unchanged, back to IDLE.
//  Illegal/NOP: word with memRead=memWrite=1 -> err one cycle after accept, no enables;
//   word 15'h0 -> done one cycle after accept, ctrl_ready stays 1.
//  Back-to-back and backpressure: ctrl_valid held high with 3 ALU words
//   -> ctrl_ready low during EXEC/WB, 3 done pulses; retired preset near 2^CNT_W-1 wraps to 0.
//  Reset in MEM: rst_n low for 1 cycle mid-load
//   -> all outputs 0 next edge, no done/err, ctrl_ready=1 after release.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the opcode decoder and the control sequencer:
// bit positions inside the 15-bit control bundle and the sequencer state encoding.
package ctrl_pkg;

    // Control bundle layout
    localparam int CW_W        = 15;
    localparam int CW_REGDST   = 14;
    localparam int CW_BRANCH   = 13;
    localparam int CW_MEMREAD  = 12;
    localparam int CW_MEMTOREG = 11;
    localparam int CW_ALUOP_HI = 10;
    localparam int CW_ALUOP_LO = 3;
    localparam int CW_MEMWRITE = 2;
    localparam int CW_ALUSRC   = 1;
    localparam int CW_REGWRITE = 0;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE_ENC = 2'd0;
    localparam logic [1:0] ST_EXEC_ENC = 2'd1;
    localparam logic [1:0] ST_MEM_ENC  = 2'd2;
    localparam logic [1:0] ST_WB_ENC   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = ST_IDLE_ENC,
        ST_EXEC = ST_EXEC_ENC,
        ST_MEM  = ST_MEM_ENC,
        ST_WB   = ST_WB_ENC
    } state_e;

    // A bundle asking for both a read and a write in one access is malformed
    function automatic logic cw_is_illegal(input logic [CW_W-1:0] w);
        return w[CW_MEMREAD] & w[CW_MEMWRITE];
    endfunction

endpackage

// File: rtl/ctrl_mem_timer.sv
// Counts cycles spent waiting on memory. expired is high during the
// MEM_TIMEOUT-th enabled cycle since the last clear, so the caller can
// still honour a mem_ready that arrives in that same cycle.
module ctrl_mem_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] cnt_q;
    logic [TW-1:0] cnt_d;

    assign expired = (cnt_q == TW'(MEM_TIMEOUT - 1));

    // Next count: clear wins, otherwise count up and saturate at expiry
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && !expired) begin
            cnt_d = cnt_q + TW'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ctrl_sequencer.sv
// Multi-cycle instruction sequencer between the opcode decoder and the datapath.
// Handshake: a bundle transfers on a rising edge where ctrl_valid && ctrl_ready;
// ctrl_ready is high only in IDLE and the sender holds ctrl_word while it is low.
// done/err mark the last active cycle of an instruction. For NOP and illegal
// bundles that cycle is the one after accept (flagged by nop_q/ill_q); in MEM
// the exit depends on mem_ready in that very cycle, so the pulse is decoded
// from the registered state together with mem_ready.
module ctrl_sequencer
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_valid,
    output logic             ctrl_ready,
    input  logic [14:0]      ctrl_word,
    input  logic             mem_ready,
    output logic             alu_en,
    output logic [7:0]       alu_op,
    output logic             alu_src,
    output logic             reg_dst,
    output logic             br_eval,
    output logic             mem_rd_en,
    output logic             mem_wr_en,
    output logic             mem_to_reg,
    output logic             reg_wr_en,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] retired,
    output logic [1:0]       state_dbg
);

    state_e              state_q, state_d;
    logic [CW_W-1:0]     word_q, word_d;
    logic                nop_q, nop_d;
    logic                ill_q, ill_d;
    logic [CNT_W-1:0]    retired_q, retired_d;
    logic                tmr_clr, tmr_en, tmr_expired;

    // Fields of the latched bundle
    logic w_branch, w_mem_rd, w_mem_wr, w_mem_to_reg, w_reg_wr;
    assign w_branch     = word_q[CW_BRANCH];
    assign w_mem_rd     = word_q[CW_MEMREAD];
    assign w_mem_wr     = word_q[CW_MEMWRITE];
    assign w_mem_to_reg = word_q[CW_MEMTOREG];
    assign w_reg_wr     = word_q[CW_REGWRITE];

    assign ctrl_ready = (state_q == ST_IDLE);
    assign alu_op     = word_q[CW_ALUOP_HI:CW_ALUOP_LO];
    assign alu_src    = word_q[CW_ALUSRC];
    assign reg_dst    = word_q[CW_REGDST];
    assign retired    = retired_q;
    assign state_dbg  = state_q;

    ctrl_mem_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expired(tmr_expired)
    );

    // Next state, latched word and per-state strobes
    always_comb begin
        state_d    = state_q;
        word_d     = word_q;
        nop_d      = 1'b0;
        ill_d      = 1'b0;
        done       = nop_q;
        err        = ill_q;
        alu_en     = 1'b0;
        br_eval    = 1'b0;
        mem_rd_en  = 1'b0;
        mem_wr_en  = 1'b0;
        mem_to_reg = 1'b0;
        reg_wr_en  = 1'b0;
        tmr_clr    = 1'b1;
        tmr_en     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // The word is only meaningful while an instruction is in flight
                word_d = '0;
                if (ctrl_valid) begin
                    word_d = ctrl_word;
                    if (ctrl_word == '0) begin
                        nop_d = 1'b1;
                    end else if (cw_is_illegal(ctrl_word)) begin
                        ill_d = 1'b1;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end
            end
            ST_EXEC: begin
                alu_en  = 1'b1;
                br_eval = w_branch;
                if (w_mem_rd || w_mem_wr) begin
                    state_d = ST_MEM;
                end else if (w_reg_wr) begin
                    state_d = ST_WB;
                end else begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                    word_d  = '0;
                end
            end
            ST_MEM: begin
                mem_rd_en = w_mem_rd;
                mem_wr_en = w_mem_wr;
                tmr_clr   = 1'b0;
                tmr_en    = 1'b1;
                if (mem_ready) begin
                    if (w_reg_wr) begin
                        state_d = ST_WB;
                    end else begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                        word_d  = '0;
                    end
                end else if (tmr_expired) begin
                    err     = 1'b1;
                    state_d = ST_IDLE;
                    word_d  = '0;
                end
            end
            ST_WB: begin
                reg_wr_en  = 1'b1;
                mem_to_reg = w_mem_to_reg;
                done       = 1'b1;
                state_d    = ST_IDLE;
                word_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                word_d  = '0;
            end
        endcase

        retired_d = retired_q + CNT_W'(done);
    end

    // State, latched word, one-shot flags and retire counter
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            nop_q     <= 1'b0;
            ill_q     <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            nop_q     <= nop_d;
            ill_q     <= ill_d;
            retired_q <= retired_d;
        end
    end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Directed bench for ctrl_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge; completion pulses are matched
// against an expected queue filled when each bundle is offered.
module tb_ctrl_sequencer;

    localparam int MT = 4;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ctrl_valid = 1'b0;
    logic [14:0]   ctrl_word = '0;
    logic          mem_ready = 1'b0;
    logic          ctrl_ready, alu_en, alu_src, reg_dst, br_eval;
    logic          mem_rd_en, mem_wr_en, mem_to_reg, reg_wr_en, done, err;
    logic [7:0]    alu_op;
    logic [CW-1:0] retired;
    logic [1:0]    state_dbg;

    int            n_chk = 0;
    int            n_fail = 0;
    logic [1:0]    exp_q[$];      // {err, done} expected per completed bundle
    logic [1:0]    mon_e;
    logic [CW-1:0] exp_ret = '0;
    logic [14:0]   b2b_words[3] = '{15'h4009, 15'h4011, 15'h47F9};
    logic [14:0]   w;

    ctrl_sequencer #(
        .MEM_TIMEOUT(MT),
        .CNT_W      (CW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ctrl_valid(ctrl_valid),
        .ctrl_ready(ctrl_ready),
        .ctrl_word (ctrl_word),
        .mem_ready (mem_ready),
        .alu_en    (alu_en),
        .alu_op    (alu_op),
        .alu_src   (alu_src),
        .reg_dst   (reg_dst),
        .br_eval   (br_eval),
        .mem_rd_en (mem_rd_en),
        .mem_wr_en (mem_wr_en),
        .mem_to_reg(mem_to_reg),
        .reg_wr_en (reg_wr_en),
        .done      (done),
        .err       (err),
        .retired   (retired),
        .state_dbg (state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: every done/err pulse must match the oldest expected completion
    always @(negedge clk) begin
        if (done === 1'b1 || err === 1'b1) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $error("FAIL sb_unexpected: observed={err,done}=%b required=no pulse", {err, done});
            end else begin
                mon_e = exp_q.pop_front();
                assert ({err, done} === mon_e) else begin
                    n_fail++;
                    $error("FAIL sb_pulse: observed={err,done}=%b required=%b", {err, done}, mon_e);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h required=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Offer one ALU bundle with regWrite in IDLE; ends in IDLE three cycles later
    task automatic run_alu(input logic [14:0] word);
        ctrl_valid = 1'b1;
        ctrl_word  = word;
        chk("alu_ready", 32'(ctrl_ready), 32'd1);
        exp_q.push_back(2'b01);
        step();
        ctrl_valid = 1'b0;
        chk("alu_en", 32'(alu_en), 32'd1);
        chk("alu_op", 32'(alu_op), 32'(word[10:3]));
        step();
        chk("alu_wb_we", 32'(reg_wr_en), 32'd1);
        chk("alu_done", 32'(done), 32'd1);
        exp_ret = exp_ret + 1'b1;
        step();
        chk("alu_retired", 32'(retired), 32'(exp_ret));
    endtask

    // Directed sequence
    initial begin
        repeat (2) step();
        rst_n = 1'b1;
        step();

        // Reset state
        chk("rst_ready", 32'(ctrl_ready), 32'd1);
        chk("rst_state", 32'(state_dbg), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_enables", 32'({alu_en, br_eval, mem_rd_en, mem_wr_en, reg_wr_en, done, err}), 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);

        // ALU op with regDst: check latched fields during EXEC
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h4009;
        exp_q.push_back(2'b01);
        step();
        ctrl_valid = 1'b0;
        chk("alu1_en", 32'(alu_en), 32'd1);
        chk("alu1_op", 32'(alu_op), 32'h01);
        chk("alu1_regdst", 32'(reg_dst), 32'd1);
        chk("alu1_ready_low", 32'(ctrl_ready), 32'd0);
        chk("alu1_no_we", 32'(reg_wr_en), 32'd0);
        step();
        chk("alu1_we", 32'(reg_wr_en), 32'd1);
        chk("alu1_done", 32'(done), 32'd1);
        exp_ret = exp_ret + 1'b1;
        step();
        chk("alu1_retired", 32'(retired), 32'(exp_ret));
        chk("alu1_idle", 32'(ctrl_ready), 32'd1);

        // mem_ready while idle has no effect
        mem_ready = 1'b1;
        step();
        chk("idle_memrdy_state", 32'(state_dbg), 32'd0);
        mem_ready = 1'b0;

        // Load: three MEM cycles, mem_ready in the third
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h1801;
        exp_q.push_back(2'b01);
        step();
        ctrl_valid = 1'b0;
        chk("ld_exec", 32'(alu_en), 32'd1);
        chk("ld_exec_rd", 32'(mem_rd_en), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ld_mem_rd", 32'(mem_rd_en), 32'd1);
            chk("ld_mem_done", 32'(done), 32'd0);
            if (i == 2) mem_ready = 1'b1;
        end
        step();
        mem_ready = 1'b0;
        chk("ld_wb_rd_off", 32'(mem_rd_en), 32'd0);
        chk("ld_wb_we", 32'(reg_wr_en), 32'd1);
        chk("ld_wb_m2r", 32'(mem_to_reg), 32'd1);
        chk("ld_done", 32'(done), 32'd1);
        exp_ret = exp_ret + 1'b1;
        step();
        chk("ld_retired", 32'(retired), 32'(exp_ret));

        // Store completing in the same cycle the timer expires
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h0004;
        exp_q.push_back(2'b01);
        step();
        ctrl_valid = 1'b0;
        chk("st_exec_wr", 32'(mem_wr_en), 32'd0);
        for (int i = 0; i < MT - 1; i++) begin
            step();
            chk("st_mem_wr", 32'(mem_wr_en), 32'd1);
        end
        @(posedge clk);
        #1 mem_ready = 1'b1;
        step();
        chk("st_edge_wr", 32'(mem_wr_en), 32'd1);
        chk("st_edge_done", 32'(done), 32'd1);
        chk("st_edge_err", 32'(err), 32'd0);
        exp_ret = exp_ret + 1'b1;
        @(posedge clk);
        #1 mem_ready = 1'b0;
        step();
        chk("st_edge_idle", 32'(state_dbg), 32'd0);
        chk("st_edge_retired", 32'(retired), 32'(exp_ret));

        // Store timeout
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h0004;
        exp_q.push_back(2'b10);
        step();
        ctrl_valid = 1'b0;
        for (int i = 0; i < MT; i++) begin
            step();
            chk("to_mem_wr", 32'(mem_wr_en), 32'd1);
            if (i == MT - 1) begin
                chk("to_err", 32'(err), 32'd1);
                chk("to_no_done", 32'(done), 32'd0);
            end
        end
        step();
        chk("to_wr_off", 32'(mem_wr_en), 32'd0);
        chk("to_err_off", 32'(err), 32'd0);
        chk("to_ready", 32'(ctrl_ready), 32'd1);
        chk("to_retired", 32'(retired), 32'(exp_ret));

        // Illegal bundle: read and write together
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h1004;
        exp_q.push_back(2'b10);
        step();
        ctrl_valid = 1'b0;
        chk("ill_err", 32'(err), 32'd1);
        chk("ill_enables", 32'({alu_en, mem_rd_en, mem_wr_en, reg_wr_en}), 32'd0);
        chk("ill_ready", 32'(ctrl_ready), 32'd1);
        step();
        chk("ill_err_off", 32'(err), 32'd0);
        chk("ill_retired", 32'(retired), 32'(exp_ret));

        // NOP
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h0000;
        exp_q.push_back(2'b01);
        step();
        ctrl_valid = 1'b0;
        chk("nop_done", 32'(done), 32'd1);
        chk("nop_ready", 32'(ctrl_ready), 32'd1);
        chk("nop_alu", 32'(alu_en), 32'd0);
        exp_ret = exp_ret + 1'b1;
        step();
        chk("nop_retired", 32'(retired), 32'(exp_ret));

        // Branch without regWrite: retires straight out of EXEC
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h2028;
        exp_q.push_back(2'b01);
        step();
        ctrl_valid = 1'b0;
        chk("br_eval", 32'(br_eval), 32'd1);
        chk("br_alu_op", 32'(alu_op), 32'h05);
        chk("br_done", 32'(done), 32'd1);
        exp_ret = exp_ret + 1'b1;
        step();
        chk("br_idle", 32'(state_dbg), 32'd0);
        chk("br_retired", 32'(retired), 32'(exp_ret));

        // Back-to-back with ctrl_valid held high
        ctrl_valid = 1'b1;
        ctrl_word  = b2b_words[0];
        for (int k = 0; k < 3; k++) begin
            chk("b2b_ready_idle", 32'(ctrl_ready), 32'd1);
            exp_q.push_back(2'b01);
            step();
            chk("b2b_ready_exec", 32'(ctrl_ready), 32'd0);
            chk("b2b_alu_op", 32'(alu_op), 32'(b2b_words[k][10:3]));
            step();
            chk("b2b_ready_wb", 32'(ctrl_ready), 32'd0);
            chk("b2b_done", 32'(done), 32'd1);
            exp_ret = exp_ret + 1'b1;
            if (k == 2) ctrl_valid = 1'b0;
            else ctrl_word = b2b_words[k + 1];
            step();
        end
        chk("b2b_retired", 32'(retired), 32'(exp_ret));

        // Drive retired through its wrap with random ALU opcodes
        while (exp_ret != '0) begin
            w = 15'h4001 | (15'($urandom_range(0, 255)) << 3);
            run_alu(w);
        end
        chk("wrap_zero", 32'(retired), 32'd0);

        // One more retire, then reset in the middle of a load
        run_alu(15'h4009);
        ctrl_valid = 1'b1;
        ctrl_word  = 15'h1801;
        step();
        ctrl_valid = 1'b0;
        step();
        chk("rst_mid_in_mem", 32'(mem_rd_en), 32'd1);
        rst_n = 1'b0;
        step();
        exp_ret = '0;
        chk("rst_mid_outputs", 32'({alu_en, br_eval, mem_rd_en, mem_wr_en, mem_to_reg, reg_wr_en, done, err}), 32'd0);
        chk("rst_mid_retired", 32'(retired), 32'd0);
        chk("rst_mid_state", 32'(state_dbg), 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_mid_ready", 32'(ctrl_ready), 32'd1);
        chk("rst_mid_rd_off", 32'(mem_rd_en), 32'd0);
        run_alu(15'h4011);

        // Every expected completion must have been seen
        repeat (2) step();
        chk("sb_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
